tinyqv_mem_arbiter: RTL
=======================

# tinyqv_mem_arbiter

Shares the single nibble-serial memory controller between the instruction prefetcher and the core's load/store path. Data accesses get priority: an active fetch is paused at the next halfword boundary, the data transfer runs, then fetching resumes at the next unfetched halfword. The block also assembles fetched nibbles into 16-bit halfwords and read data into 32-bit words, and serialises store data.

## Interface
- ADDR_BITS, 24, byte-address width of the memory space.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- instr_fetch_req  in  1  keep fetching sequential halfwords while high.
- instr_fetch_restart  in  1  one-cycle pulse: abandon the current fetch and restart at instr_addr.
- instr_addr  in  ADDR_BITS-1  halfword address [ADDR_BITS-1:1]; sampled on restart.
- instr_data  out  16  fetched halfword, valid while instr_ready.
- instr_ready  out  1  one-cycle pulse per fetched halfword.
- data_read_req, data_write_req  in  1  each held high until data_ready.
- data_addr  in  ADDR_BITS  byte address.
- data_size  in  2  0 byte, 1 half, 2 word (3 treated as word).
- data_to_write  in  32  store data, low bits used.
- data_from_read  out  32  load data, zero-extended above size.
- data_ready  out  1  one-cycle pulse: access finished.
- mem_start_read, mem_start_write  out  1  one-cycle start pulses to the controller.
- mem_addr  out  ADDR_BITS  transaction address, valid on start.
- mem_stop  out  1  one-cycle pulse ending the transaction.
- mem_busy  in  1  controller busy; starts are legal only while low.
- mem_data_in  in  4  read nibble.  mem_data_valid  in  1  read nibble valid.
- mem_data_out  out  4  current write nibble.  mem_data_taken  in  1  controller consumed mem_data_out.

## Operation
- States: IDLE, FETCH, READ, WRITE, STOP. All outputs are registered.
- IDLE, with mem_busy low: a data request starts a data access (write wins if both are high). Otherwise, instr_fetch_req with a valid fetch address starts FETCH.
- FETCH: issues mem_start_read at {fetch_addr,0}. Nibbles are shifted low-first into a 4-nibble shift register. On the 4th nibble, instr_data/instr_ready fire and fetch_addr increments by 1, wrapping to 0 past all-ones.
- At each halfword boundary, FETCH goes to STOP if any of these is true: a data request is pending, instr_fetch_req is low, or fetch_addr just wrapped to 0.
- READ: needs 2/4/8 nibbles for byte/half/word. Nibbles are placed low-first and upper bits are cleared. After the last nibble, the block goes to STOP and pulses data_ready alongside mem_stop.
- WRITE: mem_data_out is data_to_write nibble k, where k advances on each mem_data_taken. After nibble 2/4/8 is taken, the block goes to STOP with data_ready.
- STOP: mem_stop pulses for one cycle, then the block waits for mem_busy low and returns to IDLE. A paused fetch then resumes at fetch_addr, because data has priority.
- instr_fetch_restart in any state:
  - fetch_addr is loaded from instr_addr.
  - Any partial halfword is discarded.
  - In FETCH, the block goes to STOP immediately.
  - During READ/WRITE, the data access completes normally.
  - No instr_ready pulse is produced for the discarded halfword.
- If restart and a data request arrive in the same cycle, both apply: the address is latched and the data access is served first.
- mem_data_valid in IDLE/STOP is ignored, and mem_data_taken outside WRITE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, fetch_addr 0, fetch address invalid until the first restart.
- A request sampled at edge N with mem_busy low gives mem_start_* high during cycle N+1, with mem_addr valid in the same cycle.
- instr_ready/data_ready rise in the cycle after the edge that samples the final nibble. data_ready coincides with mem_stop.
- A fetch pause lasts at most 3 further nibbles plus STOP before the data start.
- Reset asserted mid-transaction clears everything asynchronously. The controller shares rstn.

## Test plan
- Restart at 0x000100, fetch_req high, nibbles 4,3,2,1,8,7,6,5 → instr_data 0x1234 then 0x5678, mem_addr 0x000200, no stop between halfwords.
- Word read at 0x000040 while IDLE with nibbles 0..7 → data_from_read 0x76543210, one data_ready coincident with mem_stop.
- Byte write of 0x000000A5 → mem_data_out 5 then A, mem_stop after the 2nd take, data_ready once.
- data_read_req asserted after the 1st nibble of a fetch → the halfword completes, then stop, data read, and fetch resumes at the next halfword.
- Restart to 0x000300 after 2 fetch nibbles → no instr_ready, immediate mem_stop, next mem_addr 0x000600.
- Fetch at the last halfword, fetch_addr all-ones → one halfword, wrap to 0, stop; rstn pulsed mid-READ → all outputs 0 at once.

Source files
------------

// File: rtl/tinyqv_mem_arbiter.sv
// Purpose: shares one nibble-serial memory controller between instruction prefetch and load/store.
// Latency: request sampled at edge N gives mem_start_* in cycle N+1; ready pulses one cycle after the last nibble.
// Backpressure: starts wait for mem_busy low; write nibbles advance on mem_data_taken; data preempts fetch at halfword boundaries.
module tinyqv_mem_arbiter #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 instr_fetch_req,
    input  logic                 instr_fetch_restart,
    input  logic [ADDR_BITS-1:1] instr_addr,
    output logic [15:0]          instr_data,
    output logic                 instr_ready,
    input  logic                 data_read_req,
    input  logic                 data_write_req,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [1:0]           data_size,
    input  logic [31:0]          data_to_write,
    output logic [31:0]          data_from_read,
    output logic                 data_ready,
    output logic                 mem_start_read,
    output logic                 mem_start_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_stop,
    input  logic                 mem_busy,
    input  logic [3:0]           mem_data_in,
    input  logic                 mem_data_valid,
    output logic [3:0]           mem_data_out,
    input  logic                 mem_data_taken
);
    localparam int FA_W = ADDR_BITS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_WRITE,
        S_STOP
    } state_t;

    state_t              state, state_d;
    logic [FA_W-1:0]     fetch_addr, fetch_addr_d, fetch_addr_inc;
    logic                fetch_valid, fetch_valid_d;
    logic [2:0]          nib_cnt, nib_cnt_d, nib_last, nib_last_d, nib_next;
    logic [11:0]         sr, sr_d;
    logic [15:0]         instr_data_d;
    logic                instr_ready_d, data_ready_d;
    logic [31:0]         data_from_read_d, wr_sh;
    logic                mem_start_read_d, mem_start_write_d, mem_stop_d;
    logic [ADDR_BITS-1:0] mem_addr_d;
    logic [3:0]          mem_data_out_d;
    logic                data_req;

    function automatic logic [2:0] last_nib(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    assign data_req       = data_read_req | data_write_req;
    assign nib_next       = nib_cnt + 3'd1;
    assign fetch_addr_inc = fetch_addr + FA_W'(1);
    assign wr_sh          = data_to_write >> {nib_next, 2'b00};

    always_comb begin
        state_d           = state;
        fetch_addr_d      = fetch_addr;
        fetch_valid_d     = fetch_valid;
        nib_cnt_d         = nib_cnt;
        nib_last_d        = nib_last;
        sr_d              = sr;
        instr_data_d      = instr_data;
        instr_ready_d     = 1'b0;
        data_from_read_d  = data_from_read;
        data_ready_d      = 1'b0;
        mem_start_read_d  = 1'b0;
        mem_start_write_d = 1'b0;
        mem_stop_d        = 1'b0;
        mem_addr_d        = mem_addr;
        mem_data_out_d    = mem_data_out;

        // A restart always updates the fetch pointer, whatever the state.
        if (instr_fetch_restart) begin
            fetch_addr_d  = instr_addr;
            fetch_valid_d = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (!mem_busy) begin
                    if (data_write_req) begin
                        state_d           = S_WRITE;
                        mem_start_write_d = 1'b1;
                        mem_addr_d        = data_addr;
                        nib_cnt_d         = 3'd0;
                        nib_last_d        = last_nib(data_size);
                        mem_data_out_d    = data_to_write[3:0];
                    end else if (data_read_req) begin
                        state_d          = S_READ;
                        mem_start_read_d = 1'b1;
                        mem_addr_d       = data_addr;
                        nib_cnt_d        = 3'd0;
                        nib_last_d       = last_nib(data_size);
                        data_from_read_d = '0;
                    end else if (instr_fetch_req && fetch_valid_d) begin
                        state_d          = S_FETCH;
                        mem_start_read_d = 1'b1;
                        mem_addr_d       = {fetch_addr_d, 1'b0};
                        nib_cnt_d        = 3'd0;
                    end
                end
            end
            S_FETCH: begin
                if (instr_fetch_restart) begin
                    state_d    = S_STOP;
                    mem_stop_d = 1'b1;
                    nib_cnt_d  = 3'd0;
                end else if (mem_data_valid) begin
                    if (nib_cnt == 3'd3) begin
                        instr_data_d  = {mem_data_in, sr};
                        instr_ready_d = 1'b1;
                        fetch_addr_d  = fetch_addr_inc;
                        nib_cnt_d     = 3'd0;
                        if (data_req || !instr_fetch_req || fetch_addr_inc == '0) begin
                            state_d    = S_STOP;
                            mem_stop_d = 1'b1;
                        end
                        // Running off the top of memory needs a new restart to continue.
                        if (fetch_addr_inc == '0) fetch_valid_d = 1'b0;
                    end else begin
                        sr_d      = {mem_data_in, sr[11:4]};
                        nib_cnt_d = nib_next;
                    end
                end
            end
            S_READ: begin
                if (mem_data_valid) begin
                    data_from_read_d = data_from_read | (32'(mem_data_in) << {nib_cnt, 2'b00});
                    if (nib_cnt == nib_last) begin
                        state_d      = S_STOP;
                        mem_stop_d   = 1'b1;
                        data_ready_d = 1'b1;
                    end else begin
                        nib_cnt_d = nib_next;
                    end
                end
            end
            S_WRITE: begin
                if (mem_data_taken) begin
                    if (nib_cnt == nib_last) begin
                        state_d      = S_STOP;
                        mem_stop_d   = 1'b1;
                        data_ready_d = 1'b1;
                    end else begin
                        nib_cnt_d      = nib_next;
                        mem_data_out_d = wr_sh[3:0];
                    end
                end
            end
            S_STOP: begin
                if (!mem_stop && !mem_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            fetch_addr      <= '0;
            fetch_valid     <= 1'b0;
            nib_cnt         <= '0;
            nib_last        <= '0;
            sr              <= '0;
            instr_data      <= '0;
            instr_ready     <= 1'b0;
            data_from_read  <= '0;
            data_ready      <= 1'b0;
            mem_start_read  <= 1'b0;
            mem_start_write <= 1'b0;
            mem_stop        <= 1'b0;
            mem_addr        <= '0;
            mem_data_out    <= '0;
        end else begin
            state           <= state_d;
            fetch_addr      <= fetch_addr_d;
            fetch_valid     <= fetch_valid_d;
            nib_cnt         <= nib_cnt_d;
            nib_last        <= nib_last_d;
            sr              <= sr_d;
            instr_data      <= instr_data_d;
            instr_ready     <= instr_ready_d;
            data_from_read  <= data_from_read_d;
            data_ready      <= data_ready_d;
            mem_start_read  <= mem_start_read_d;
            mem_start_write <= mem_start_write_d;
            mem_stop        <= mem_stop_d;
            mem_addr        <= mem_addr_d;
            mem_data_out    <= mem_data_out_d;
        end
    end
endmodule
